wbf_weight_buf: RTL

//  Weight Buffer: upstream of the weight cache arbiter (WCA). Top fills it with a layer's weights, then it

---
 rtl/wbf_weight_buf_pkg.sv | 19 +
 rtl/wbf_weight_buf_if.sv | 25 ++
 rtl/wbf_weight_buf_ram_sp.sv | 28 ++
 rtl/wbf_weight_buf.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wbf_weight_buf_pkg.sv
// wca_pkg: shared widths, config opcodes and FSM state type for the weight
// cache arbiter slice (weight buffer and friends).
package wca_pkg;

    localparam int ISA_WIDTH      = 2;
    localparam int DATA_WIDTH     = 8;
    localparam int WEI_ADDR_WIDTH = 8;

    localparam logic [ISA_WIDTH-1:0] ISA_LOAD_SERVE = 2'b00;
    localparam logic [ISA_WIDTH-1:0] ISA_SERVE_ONLY = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SERVE,
        DRAIN
    } wbfState_t;

endpackage

// File: rtl/wbf_weight_buf_if.sv
// wbf_weight_buf_if: WCA read bus (address handshake in, data handshake out).
// master = weight cache arbiter side, slave = weight buffer side.
interface wbf_weight_buf_if #(
    parameter int DATA_WIDTH     = wca_pkg::DATA_WIDTH,
    parameter int WEI_ADDR_WIDTH = wca_pkg::WEI_ADDR_WIDTH
);

    logic                      WCAWBF_AdrVld;
    logic [WEI_ADDR_WIDTH-1:0] WCAWBF_Adr;
    logic                      WBFWCA_AdrRdy;
    logic                      WBFWCA_DatVld;
    logic [DATA_WIDTH-1:0]     WBFWCA_Dat;
    logic                      WCAWBF_DatRdy;

    modport master (
        output WCAWBF_AdrVld, WCAWBF_Adr, WCAWBF_DatRdy,
        input  WBFWCA_AdrRdy, WBFWCA_DatVld, WBFWCA_Dat
    );

    modport slave (
        input  WCAWBF_AdrVld, WCAWBF_Adr, WCAWBF_DatRdy,
        output WBFWCA_AdrRdy, WBFWCA_DatVld, WBFWCA_Dat
    );

endinterface

// File: rtl/wbf_weight_buf_ram_sp.sv
// wbf_ram_sp: behavioural single-port RAM, registered read (1-cycle latency),
// write-enable, contents not reset.
module wbf_ram_sp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // One access per cycle: write when we, otherwise register the read word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/wbf_weight_buf.sv
// wbf_weight_buf: weight buffer in front of the weight cache arbiter.
// Loads a layer of weights into a single-port RAM, then serves in-order reads
// through a small output FIFO. Optional macro WBF_OOR_CHK_EN adds a range check
// of read addresses against the latched layer size and a sticky WBFTOP_Err.
module wbf_weight_buf #(
    parameter int ISA_WIDTH      = wca_pkg::ISA_WIDTH,
    parameter int DATA_WIDTH     = wca_pkg::DATA_WIDTH,
    parameter int WEI_ADDR_WIDTH = wca_pkg::WEI_ADDR_WIDTH,
    parameter int OFIFO_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    TOPWBF_CfgVld,
    input  logic [ISA_WIDTH-1:0]    TOPWBF_CfgISA,
    input  logic [WEI_ADDR_WIDTH:0] TOPWBF_CfgNum,
    output logic                    WBFTOP_CfgRdy,
    input  logic                    TOPWBF_LayerDone,
    input  logic                    TOPWBF_DatVld,
    input  logic [DATA_WIDTH-1:0]   TOPWBF_Dat,
    output logic                    WBFTOP_DatRdy,
`ifdef WBF_OOR_CHK_EN
    output logic                    WBFTOP_Err,
`endif
    wbf_weight_buf_if.slave         wca
);

    import wca_pkg::*;

    localparam int FPW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
    localparam int FCW = $clog2(OFIFO_DEPTH + 1);
    localparam logic [FPW-1:0] FIFO_LAST = FPW'(OFIFO_DEPTH - 1);

    wbfState_t               state, stateNxt;
    logic [WEI_ADDR_WIDTH:0] num;
    logic [WEI_ADDR_WIDTH:0] wrPtr;
    logic                    outOfReset;

    logic [DATA_WIDTH-1:0]   fifoMem [OFIFO_DEPTH];
    logic [FPW-1:0]          fifoRdPtr, fifoWrPtr;
    logic [FCW-1:0]          occ;
    logic                    inflight;

    logic                    cfgRdy, datRdy, adrRdy;
    logic                    isaLoad, isaServe;
    logic                    cfgXfer, cfgAccept, ldXfer, adrXfer, rdEn;
    logic                    push, pop;
    logic                    ramEn;
    logic [WEI_ADDR_WIDTH-1:0] ramAddr;
    logic [DATA_WIDTH-1:0]   ramRdata, pushDat;

    // Ready flags and transfer strobes; every ready depends on registers only.
    always_comb begin
        cfgRdy    = (state == IDLE) && outOfReset;
        datRdy    = (state == LOAD);
        adrRdy    = (state == SERVE) &&
                    ((32'(occ) + 32'(inflight)) < 32'(OFIFO_DEPTH));
        isaLoad   = (TOPWBF_CfgISA == ISA_WIDTH'(ISA_LOAD_SERVE));
        isaServe  = (TOPWBF_CfgISA == ISA_WIDTH'(ISA_SERVE_ONLY));
        cfgXfer   = TOPWBF_CfgVld && cfgRdy;
        cfgAccept = cfgXfer && (isaLoad || isaServe);
        ldXfer    = TOPWBF_DatVld && datRdy;
        adrXfer   = wca.WCAWBF_AdrVld && adrRdy;
        push      = inflight;
        pop       = (occ != '0) && wca.WCAWBF_DatRdy;
    end

`ifdef WBF_OOR_CHK_EN
    logic adrOor;
    logic inflightOor;
    logic errReg;

    assign adrOor     = ({1'b0, wca.WCAWBF_Adr} >= num);
    assign rdEn       = adrXfer && !adrOor;
    assign pushDat    = inflightOor ? '0 : ramRdata;
    assign WBFTOP_Err = errReg;

    // Out-of-range tracking: suppressed read slot and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflightOor <= 1'b0;
            errReg      <= 1'b0;
        end else begin
            inflightOor <= adrXfer && adrOor;
            if (cfgAccept) begin
                errReg <= 1'b0;
            end else if (adrXfer && adrOor) begin
                errReg <= 1'b1;
            end
        end
    end
`else
    assign rdEn    = adrXfer;
    assign pushDat = ramRdata;
`endif

    // Single RAM port: load writes own it in LOAD, read addresses otherwise.
    always_comb begin
        ramEn   = ldXfer || rdEn;
        ramAddr = (state == LOAD) ? wrPtr[WEI_ADDR_WIDTH-1:0] : wca.WCAWBF_Adr;
    end

    wbf_ram_sp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (WEI_ADDR_WIDTH)
    ) uRam (
        .clk   (clk),
        .en    (ramEn),
        .we    (ldXfer),
        .addr  (ramAddr),
        .wdata (TOPWBF_Dat),
        .rdata (ramRdata)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        stateNxt = state;
        case (state)
            IDLE: begin
                if (cfgXfer && isaLoad) begin
                    stateNxt = (TOPWBF_CfgNum == '0) ? SERVE : LOAD;
                end else if (cfgXfer && isaServe) begin
                    stateNxt = SERVE;
                end
            end
            LOAD: begin
                if (ldXfer && (wrPtr == num - 1'b1)) begin
                    stateNxt = SERVE;
                end
            end
            SERVE: begin
                if (TOPWBF_LayerDone) begin
                    stateNxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((occ == '0) && !inflight) begin
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    // Layer size latch, load pointer and post-reset ready qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num        <= '0;
            wrPtr      <= '0;
            outOfReset <= 1'b0;
        end else begin
            outOfReset <= 1'b1;
            if (cfgAccept) begin
                num   <= TOPWBF_CfgNum;
                wrPtr <= '0;
            end else if (ldXfer) begin
                wrPtr <= wrPtr + 1'b1;
            end
        end
    end

    // Output FIFO control: the RAM word read last cycle is pushed this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifoRdPtr <= '0;
            fifoWrPtr <= '0;
            occ       <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= adrXfer;
            if (push) begin
                fifoWrPtr <= (fifoWrPtr == FIFO_LAST) ? '0 : fifoWrPtr + 1'b1;
            end
            if (pop) begin
                fifoRdPtr <= (fifoRdPtr == FIFO_LAST) ? '0 : fifoRdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // FIFO storage, no reset needed: empty entries are masked at the output.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[fifoWrPtr] <= pushDat;
        end
    end

    assign WBFTOP_CfgRdy     = cfgRdy;
    assign WBFTOP_DatRdy     = datRdy;
    assign wca.WBFWCA_AdrRdy = adrRdy;
    assign wca.WBFWCA_DatVld = (occ != '0);
    assign wca.WBFWCA_Dat    = (occ != '0) ? fifoMem[fifoRdPtr] : '0;

endmodule
